// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and helpers for the UART receive FIFO.
// The optional idle timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
package uart_pkg;

    localparam int DEPTH_DEF     = 8;
    localparam int WIDTH_DEF     = 8;
    localparam int TO_CYCLES_DEF = 3480;

    // Level counter must be able to hold the value DEPTH itself.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver/bus-side handshake bundle of the UART receive FIFO.
// The master side is the receiver plus bus read path; the slave side is the FIFO.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
)();

    localparam int LW = level_w(DEPTH);

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [LW-1:0]    thresh;
    logic             clr;
    logic             flush;
    logic [WIDTH-1:0] rd_data;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             overrun;
    logic             intr_rx;
    logic             timeout;

    modport master (
        output push, push_data, pop, thresh, clr, flush,
        input  rd_data, level, empty, full, overrun, intr_rx, timeout
    );

    modport slave (
        input  push, push_data, pop, thresh, clr, flush,
        output rd_data, level, empty, full, overrun, intr_rx, timeout
    );

endinterface

// File: rtl/uart_rx_fifo_timeout.sv
// Idle timeout for the receive FIFO: counts cycles with data waiting and no activity.
// Only instantiated when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic empty,
    input  logic activity,
    input  logic clr,
    output logic timeout
);

    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] count;
    logic          set;

    assign set = !empty && !activity && (count == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            if (activity || empty) begin
                count <= '0;
            end else if (count != CW'(TO_CYCLES)) begin
                count <= count + 1'b1;
            end
            // A timeout reached on the same edge as a clear still latches.
            if (set) begin
                timeout <= 1'b1;
            end else if (clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the bus read path (first-word fall-through).
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle timeout flag; otherwise timeout is 0.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int TO_CYCLES = TO_CYCLES_DEF
)(
    input  logic           clk_i,
    input  logic           rst_i,
    uart_rx_fifo_if.slave  bus
);

    localparam int LW = level_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [LW-1:0]    level;
    logic             overrun;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             overrun_set;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push     = bus.push && (!full || bus.pop) && !bus.flush;
    assign do_pop      = bus.pop && !empty && !bus.flush;
    assign overrun_set = bus.push && full && !bus.pop && !bus.flush;

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem[wptr] <= bus.push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (bus.flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_pop) begin
                    rptr <= rptr + 1'b1;
                end
                if (do_push && !do_pop) begin
                    level <= level + 1'b1;
                end else if (!do_push && do_pop) begin
                    level <= level - 1'b1;
                end
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (bus.clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus.rd_data = empty ? '0 : mem[rptr];
    assign bus.level   = level;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.overrun = overrun;
    assign bus.intr_rx = (bus.thresh != '0) && (level >= bus.thresh);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    uart_rx_timeout #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .empty    (empty),
        .activity (bus.push | bus.pop | bus.flush | bus.clr),
        .clr      (bus.clr),
        .timeout  (bus.timeout)
    );
`else
    // No idle counter in this build; the expression is constant 0.
    assign bus.timeout = (TO_CYCLES < 0);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a byte-queue scoreboard predicts every output.
// The timeout section follows UART_RX_FIFO_TIMEOUT_EN like the design.
module tb_uart_rx_fifo;

    localparam int DEPTH     = 8;
    localparam int WIDTH     = 8;
    localparam int TO_CYCLES = 3480;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] model[$];
    logic       ovr_model = 1'b0;
    int         checks    = 0;
    int         errors    = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkState();
        int sz;
        sz = model.size();
        checkOutput("level", 32'(bus.level), 32'(sz));
        checkOutput("empty", 32'(bus.empty), 32'(sz == 0));
        checkOutput("full", 32'(bus.full), 32'(sz == DEPTH));
        checkOutput("overrun", 32'(bus.overrun), 32'(ovr_model));
        checkOutput("intr_rx", 32'(bus.intr_rx), 32'((bus.thresh != 0) && (sz >= int'(bus.thresh))));
        checkOutput("rd_data", 32'(bus.rd_data), (sz == 0) ? 32'h0 : 32'(model[0]));
`ifndef UART_RX_FIFO_TIMEOUT_EN
        checkOutput("timeout_off", 32'(bus.timeout), 32'h0);
`endif
    endtask

    // One clock with the given strobes; the scoreboard is updated from what was driven.
    task automatic applyStimulus(input logic p, input logic [7:0] d, input logic pp,
                                 input logic f, input logic c);
        logic full_before;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = pp;
        bus.flush     = f;
        bus.clr       = c;
        full_before   = (model.size() == DEPTH);
        if (f) begin
            model.delete();
        end else begin
            if (pp && model.size() > 0) begin
                checkOutput("pop_data", 32'(bus.rd_data), 32'(model[0]));
                void'(model.pop_front());
            end
            if (p && (!full_before || pp)) begin
                model.push_back(d);
            end
        end
        if (!f && p && full_before && !pp) begin
            ovr_model = 1'b1;
        end else if (c) begin
            ovr_model = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
        bus.clr   = 1'b0;
        checkState();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model.delete();
        ovr_model = 1'b0;
        checkState();
    endtask

    initial begin
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop       = 1'b0;
        bus.thresh    = '0;
        bus.clr       = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);
        applyReset();
        checkOutput("reset_timeout", 32'(bus.timeout), 32'h0);

        // Single byte in and out.
        applyStimulus(1, 8'hA5, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);

        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) applyStimulus(1, 8'(i), 0, 0, 0);
        applyStimulus(1, 8'h09, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);

        // Offset the pointers, then fill again so storage wraps.
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h21 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h31 + i), 0, 0, 0);

        // Clear overrun, then push+pop while full: no overrun, 0x55 becomes tail.
        applyStimulus(0, 8'h00, 0, 0, 1);
        applyStimulus(1, 8'h55, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 1, 0, 0);

        // Push+pop while empty acts as a push only.
        applyStimulus(1, 8'h66, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);

        // Threshold interrupt.
        bus.thresh = 4'd4;
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'h40 + i), 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        bus.thresh = 4'd0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h50 + i), 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Flush keeps overrun; reset clears it.
        for (int i = 0; i < 9; i++) applyStimulus(1, 8'(8'h70 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0);
        applyStimulus(1, 8'h99, 1, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h80 + i), 0, 0, 0);
        applyReset();

`ifdef UART_RX_FIFO_TIMEOUT_EN
        applyStimulus(1, 8'hC3, 0, 0, 0);
        for (int i = 0; i < TO_CYCLES - 1; i++) applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("timeout_early", 32'(bus.timeout), 32'h0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("timeout_set", 32'(bus.timeout), 32'h1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("timeout_clr", 32'(bus.timeout), 32'h0);
        applyStimulus(0, 8'h00, 0, 1, 0);
`else
        applyStimulus(1, 8'hC3, 0, 0, 0);
        for (int i = 0; i < TO_CYCLES + 10; i++) applyStimulus(0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);
`endif

        // Random traffic against the scoreboard.
        bus.thresh = 4'd3;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer for the UART peripheral, placed directly downstream of the UART receiver and upstream of the register/bus read path. Captures each byte the receiver completes, holds up to DEPTH bytes in arrival order, presents the oldest byte to the bus read data register, and raises level, overrun and (optionally) timeout interrupts. This lets software drain received bytes in bursts instead of once per character.

## Interface
- DEPTH, 8, number of byte entries; power of two, ≥2
- WIDTH, 8, data bits per entry
- TO_CYCLES, 3480, idle clock cycles before the timeout flag sets (about 4 character times at baud divisor 87)
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- push_i  in  1  one-cycle strobe from the receiver: byte complete
- push_data_i  in  WIDTH  received byte, valid with push_i
- pop_i  in  1  one-cycle strobe from the bus: data register read
- thresh_i  in  $clog2(DEPTH+1)  interrupt threshold level
- clr_i  in  1  one-cycle strobe: clear overrun and timeout flags
- flush_i  in  1  one-cycle strobe: discard all entries
- rd_data_o  out  WIDTH  oldest byte (first-word fall-through); 0 when empty
- level_o  out  $clog2(DEPTH+1)  number of stored bytes
- empty_o  out  1  level_o == 0
- full_o  out  1  level_o == DEPTH
- overrun_o  out  1  sticky: a push arrived while full
- intr_rx_o  out  1  level_o ≥ thresh_i and thresh_i ≠ 0
- timeout_o  out  1  sticky idle timeout flag (0 when macro absent)

## Operation
- Storage: DEPTH×WIDTH register array; write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH; a separate level counter distinguishes full from empty.
- Push when not full: write push_data_i at wptr, wptr+1, level+1.
- Push when full: data dropped, no state change except overrun_o ← 1.
- Pop when not empty: rptr+1, level−1. Pop when empty: ignored, no underflow.
- Push and pop together: not empty and not full → both take effect, level unchanged; empty → push only (level 0→1); full → both take effect, level stays DEPTH, no overrun.
- flush_i: pointers and level to 0; takes priority over push/pop in the same cycle; flags unaffected.
- clr_i clears overrun_o and timeout_o; a setting event in the same cycle wins (flag stays 1).
- intr_rx_o is combinational from level_o and thresh_i; thresh_i = 0 disables it.

## Timing
- Reset: pointers, level_o, overrun_o, timeout_o = 0; empty_o = 1, full_o = 0, intr_rx_o = 0, rd_data_o = 0. Array contents are not reset.
- Reset mid-operation discards all entries on that edge and has priority over every other input.
- Push latency: a byte pushed at edge N appears on rd_data_o and in level_o after edge N (visible in cycle N+1).
- Pop: rd_data_o shows the next entry right after the popping edge.
- All flags update on the clock edge following the causing strobe.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined: idle counter runs while empty_o = 0. It resets on any push, pop, flush or clr. When it reaches TO_CYCLES, timeout_o ← 1 and the counter holds. The counter is held at 0 while empty.
- Not defined: no counter is built; timeout_o is tied to 0.

## Structure
- The uart_pkg package holds the default DEPTH/WIDTH/TO_CYCLES constants and the level-width localparam function.
- One sub-module, uart_rx_timeout, holds the idle counter and flag. It is instantiated only under the macro.

## Test plan
- Reset, then push 0xA5 → next cycle rd_data_o = 0xA5, level_o = 1, empty_o = 0; pop → empty_o = 1, rd_data_o = 0.
- Push 0x01..0x08 (DEPTH = 8) → full_o = 1; push 0x09 → overrun_o = 1, level stays 8; pop ×8 returns 0x01..0x08 in order (wrap exercised by a second fill).
- When full, push 0x55 and pop in the same cycle → level 8, overrun_o = 0, tail entry = 0x55; when empty, push and pop in the same cycle → level 1.
- Set thresh_i = 4 → intr_rx_o rises after the 4th push and falls after the next pop; thresh_i = 0 → never asserts.
- With the macro defined: push one byte, then idle 3480 cycles → timeout_o = 1; clr_i → 0. Without the macro: timeout_o stays 0.
- Assert rst_i or flush_i with 5 entries stored → level_o = 0, empty_o = 1; overrun_o is cleared by rst_i only.
